// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
// Scans a 4x4 hex keypad by driving one column low at a time and sensing the
// rows. Each full scan of all four columns is classified as no key, exactly one
// key, or several keys. A per-scan debounce FSM turns stable single-key scans
// into one key code per press. The code is offered to the consumer on a
// level-held valid / acknowledge handshake.
module hex_keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 131072,  // clocks per column dwell, >= 4
    parameter int unsigned DEBOUNCE_SCANS = 4        // stable scans to accept/release, 1..15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] ROW_IN,
    output logic [3:0] COL_SEL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       KEY_HELD,
    output logic       OVERRUN
);

    localparam logic [16:0] DWELL_LAST = 17'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_TARGET  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [3:0] code;
    } scan_result_t;

    // Classify a full scan image: no bits, exactly one bit (with its index), or more.
    function automatic scan_result_t classify(input logic [15:0] img);
        scan_result_t res;
        logic [4:0]   ones;
        ones     = 5'd0;
        res.code = 4'h0;
        res.cls  = CLS_NONE;
        for (int i = 0; i < 16; i++) begin
            if (img[i]) begin
                ones     = ones + 5'd1;
                res.code = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            res.cls = CLS_NONE;
        end else if (ones == 5'd1) begin
            res.cls = CLS_SINGLE;
        end else begin
            res.cls = CLS_MULTI;
        end
        return res;
    endfunction

    // Row synchroniser; idle rows read high because of the board pull-ups.
    logic [3:0]   row_meta_q;
    logic [3:0]   row_sync_q;
    logic [3:0]   row_s;

    // Scan timing and image.
    logic [16:0]  dwell_q;
    logic [16:0]  dwell_d;
    logic [1:0]   col_q;
    logic [1:0]   col_d;
    logic [3:0]   col_sel_q;
    logic [15:0]  img_q;
    logic [15:0]  img_d;
    logic         dwell_wrap;
    logic         scan_end;
    scan_result_t scan_res;

    // Debounce FSM.
    state_t       state_q;
    state_t       state_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [3:0]   cnt_inc;
    logic [3:0]   cand_q;
    logic [3:0]   cand_d;
    logic         accept;
    logic [3:0]   accept_code;

    // Handshake outputs.
    logic [3:0]   key_code_q;
    logic         key_valid_q;
    logic         key_held_q;
    logic         overrun_q;

    assign row_s      = ~row_sync_q;
    assign dwell_wrap = (dwell_q == DWELL_LAST);
    assign scan_end   = dwell_wrap && (col_q == 2'd3);
    assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= ROW_IN;
            row_sync_q <= row_meta_q;
        end
    end

    // Next dwell/column and the scan image with the current column's rows merged in.
    always_comb begin
        dwell_d = dwell_wrap ? 17'd0 : dwell_q + 17'd1;
        col_d   = dwell_wrap ? col_q + 2'd1 : col_q;
        img_d   = img_q;
        if (dwell_wrap) begin
            for (int r = 0; r < 4; r++) begin
                img_d[4 * r + int'(col_q)] = row_s[r];
            end
        end
    end

    // The last column's sample lands on the same edge as classification, so
    // classify the merged image rather than the stored one.
    assign scan_res = classify(img_d);

    // Dwell counter, column strobe and scan image registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dwell_q   <= 17'd0;
            col_q     <= 2'd0;
            col_sel_q <= 4'b1110;
            img_q     <= 16'h0000;
        end else begin
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            col_sel_q <= ~(4'b0001 << col_d);
            img_q     <= img_d;
        end
    end

    // Debounce FSM next-state decision, evaluated only at the end of a full scan.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        accept      = 1'b0;
        accept_code = cand_q;
        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res.cls == CLS_SINGLE) begin
                        cand_d = scan_res.code;
                        if (DB_TARGET == 4'd1) begin
                            state_d     = ST_PRESSED;
                            cnt_d       = 4'd0;
                            accept      = 1'b1;
                            accept_code = scan_res.code;
                        end else begin
                            state_d = ST_CAND;
                            cnt_d   = 4'd1;
                        end
                    end else if (scan_res.cls == CLS_MULTI) begin
                        state_d = ST_RELEASE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_CAND: begin
                    if (scan_res.cls == CLS_SINGLE && scan_res.code == cand_q) begin
                        if (cnt_inc == DB_TARGET) begin
                            state_d = ST_PRESSED;
                            cnt_d   = 4'd0;
                            accept  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (scan_res.cls == CLS_MULTI) begin
                        state_d = ST_RELEASE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_PRESSED, ST_RELEASE: begin
                    // Any key activity restarts the release count; rollover is ignored.
                    if (scan_res.cls == CLS_NONE) begin
                        if (cnt_inc == DB_TARGET) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // FSM state and registered handshake outputs; an accept overrides a same-edge ack.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            key_held_q <= (state_d == ST_PRESSED);
            if (accept) begin
                key_code_q  <= accept_code;
                key_valid_q <= 1'b1;
                // Pending unacknowledged code is lost; a same-edge ack consumed it.
                if (key_valid_q) begin
                    overrun_q <= !KEY_ACK;
                end
            end else if (KEY_ACK && key_valid_q) begin
                key_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
        end
    end

    assign COL_SEL   = col_sel_q;
    assign KEY_CODE  = key_code_q;
    assign KEY_VALID = key_valid_q;
    assign KEY_HELD  = key_held_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed testbench for hex_keypad_scanner with a behavioural 4x4 keypad
// matrix (pressed key shorts its column drive onto its row line).
module tb_hex_keypad_scanner;

    logic        clk;
    logic        Reset_n;
    logic [3:0]  ROW_IN;
    logic [3:0]  COL_SEL;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic        KEY_ACK;
    logic        KEY_HELD;
    logic        OVERRUN;

    logic [15:0] keys;
    logic [3:0]  row_drv;

    int checks   = 0;
    int failures = 0;

    hex_keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .Clk       (clk),
        .Reset_n   (Reset_n),
        .ROW_IN    (ROW_IN),
        .COL_SEL   (COL_SEL),
        .KEY_CODE  (KEY_CODE),
        .KEY_VALID (KEY_VALID),
        .KEY_ACK   (KEY_ACK),
        .KEY_HELD  (KEY_HELD),
        .OVERRUN   (OVERRUN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4 * r + c] && !COL_SEL[c]) row_drv[r] = 1'b0;
            end
        end
    end
    assign ROW_IN = row_drv;

    // Returns #1 after the edge on which COL_SEL wraps 0111 -> 1110 (end of a full scan).
    task automatic wait_scan_end();
        int         n;
        logic [3:0] prev;
        n = 0;
        do begin
            prev = COL_SEL;
            @(posedge clk);
            #1;
            n++;
        end while (!(prev == 4'b0111 && COL_SEL == 4'b1110) && n < 40);
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL scan_end_timeout: no scan boundary within %0d clocks, COL_SEL=%b", n, COL_SEL);
        end
    endtask

    task automatic pulse_ack();
        KEY_ACK = 1'b1;
        @(posedge clk);
        #1;
        KEY_ACK = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols [4];
        exp_cols[0] = 4'b1101;
        exp_cols[1] = 4'b1011;
        exp_cols[2] = 4'b0111;
        exp_cols[3] = 4'b1110;
        Reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) Reset_n = 1'b1;
        #1;
        checks++; if (COL_SEL !== 4'b1110) begin failures++; $display("FAIL reset_colsel: got %b want 1110", COL_SEL); end
        checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", KEY_VALID); end
        checks++; if (KEY_CODE !== 4'h0) begin failures++; $display("FAIL reset_code: got %h want 0", KEY_CODE); end
        checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
        checks++; if (KEY_HELD !== 1'b0) begin failures++; $display("FAIL reset_held: got %b want 0", KEY_HELD); end
        // Reset in the middle of column 1's dwell.
        repeat (6) @(posedge clk);
        #1;
        Reset_n = 1'b0;
        #1;
        checks++; if (COL_SEL !== 4'b1110) begin failures++; $display("FAIL reset_async_colsel: got %b want 1110", COL_SEL); end
        @(negedge clk) Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (COL_SEL !== exp_cols[i]) begin
                failures++;
                $display("FAIL colsel_step%0d: got %b want %b", i, COL_SEL, exp_cols[i]);
            end
        end
    endtask

    task automatic test_single_press();
        wait_scan_end();
        keys = 16'h0200;  // key 9: row 2, column 1
        wait_scan_end();
        checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL press_scan1_valid: got %b want 0", KEY_VALID); end
        wait_scan_end();
        checks++; if (KEY_CODE !== 4'h9) begin failures++; $display("FAIL press_code: got %h want 9", KEY_CODE); end
        checks++; if (KEY_VALID !== 1'b1) begin failures++; $display("FAIL press_valid: got %b want 1", KEY_VALID); end
        checks++; if (KEY_HELD !== 1'b1) begin failures++; $display("FAIL press_held: got %b want 1", KEY_HELD); end
        pulse_ack();
        checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL ack_valid: got %b want 0", KEY_VALID); end
        // Ack with nothing pending must not disturb anything.
        pulse_ack();
        checks++; if (KEY_VALID !== 1'b0 || KEY_CODE !== 4'h9) begin
            failures++; $display("FAIL idle_ack: valid=%b code=%h want valid=0 code=9", KEY_VALID, KEY_CODE);
        end
        for (int s = 0; s < 10; s++) begin
            wait_scan_end();
            checks++;
            if (KEY_VALID !== 1'b0 || KEY_HELD !== 1'b1) begin
                failures++;
                $display("FAIL hold_scan%0d: valid=%b held=%b want valid=0 held=1", s, KEY_VALID, KEY_HELD);
            end
        end
        keys = 16'h0000;
        wait_scan_end();
        checks++; if (KEY_HELD !== 1'b1) begin failures++; $display("FAIL release1_held: got %b want 1", KEY_HELD); end
        wait_scan_end();
        checks++; if (KEY_HELD !== 1'b0) begin failures++; $display("FAIL release2_held: got %b want 0", KEY_HELD); end
    endtask

    task automatic test_bounce();
        keys = 16'h0200;
        wait_scan_end();
        keys = 16'h0000;
        wait_scan_end();
        checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL bounce_valid: got %b want 0", KEY_VALID); end
        wait_scan_end();
        checks++; if (KEY_VALID !== 1'b0 || KEY_HELD !== 1'b0) begin
            failures++; $display("FAIL bounce_idle: valid=%b held=%b want 0 0", KEY_VALID, KEY_HELD);
        end
    endtask

    task automatic test_multi_key();
        keys = 16'h8001;  // keys 0 and F together
        for (int s = 0; s < 4; s++) begin
            wait_scan_end();
            checks++;
            if (KEY_VALID !== 1'b0 || KEY_HELD !== 1'b0) begin
                failures++;
                $display("FAIL multi_scan%0d: valid=%b held=%b want 0 0", s, KEY_VALID, KEY_HELD);
            end
        end
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
        keys = 16'h0008;  // key 3: row 0, column 3
        wait_scan_end();
        wait_scan_end();
        checks++; if (KEY_CODE !== 4'h3) begin failures++; $display("FAIL multi_then_code: got %h want 3", KEY_CODE); end
        checks++; if (KEY_VALID !== 1'b1) begin failures++; $display("FAIL multi_then_valid: got %b want 1", KEY_VALID); end
        pulse_ack();
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
    endtask

    task automatic test_overrun();
        keys = 16'h0020;  // key 5
        wait_scan_end();
        wait_scan_end();
        checks++; if (KEY_CODE !== 4'h5 || KEY_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL ovr_first: code=%h valid=%b ovr=%b want 5 1 0", KEY_CODE, KEY_VALID, OVERRUN);
        end
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
        keys = 16'h0400;  // key A
        wait_scan_end();
        wait_scan_end();
        checks++; if (KEY_CODE !== 4'hA) begin failures++; $display("FAIL ovr_code: got %h want a", KEY_CODE); end
        checks++; if (KEY_VALID !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b want 1", KEY_VALID); end
        checks++; if (OVERRUN !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", OVERRUN); end
        pulse_ack();
        checks++; if (KEY_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
            failures++; $display("FAIL ovr_ack: valid=%b ovr=%b want 0 0", KEY_VALID, OVERRUN);
        end
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
        // Second round: ack lands exactly on the accept edge.
        keys = 16'h0020;
        wait_scan_end();
        wait_scan_end();
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
        keys = 16'h0400;
        wait_scan_end();
        repeat (15) @(posedge clk);
        #1;
        checks++; if (KEY_VALID !== 1'b1 || KEY_CODE !== 4'h5) begin
            failures++; $display("FAIL ovr2_pending: valid=%b code=%h want 1 5", KEY_VALID, KEY_CODE);
        end
        pulse_ack();
        checks++; if (COL_SEL !== 4'b1110 || KEY_CODE !== 4'hA) begin
            failures++; $display("FAIL ovr2_accept_edge: colsel=%b code=%h want 1110 a", COL_SEL, KEY_CODE);
        end
        checks++; if (KEY_VALID !== 1'b1) begin failures++; $display("FAIL ovr2_valid: got %b want 1", KEY_VALID); end
        checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr2_flag: got %b want 0", OVERRUN); end
        pulse_ack();
        checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL ovr2_ack: got %b want 0", KEY_VALID); end
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
    endtask

    task automatic test_reset_mid_press();
        keys = 16'h0080;  // key 7: row 1, column 3
        wait_scan_end();
        wait_scan_end();
        checks++; if (KEY_CODE !== 4'h7 || KEY_HELD !== 1'b1) begin
            failures++; $display("FAIL rmp_press: code=%h held=%b want 7 1", KEY_CODE, KEY_HELD);
        end
        repeat (5) @(posedge clk);
        #1;
        Reset_n = 1'b0;
        #1;
        checks++; if (COL_SEL !== 4'b1110 || KEY_VALID !== 1'b0 || KEY_CODE !== 4'h0 ||
                      KEY_HELD !== 1'b0 || OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL rmp_reset: colsel=%b valid=%b code=%h held=%b ovr=%b want 1110 0 0 0 0",
                     COL_SEL, KEY_VALID, KEY_CODE, KEY_HELD, OVERRUN);
        end
        @(negedge clk) Reset_n = 1'b1;
        wait_scan_end();
        checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL rmp_scan1_valid: got %b want 0", KEY_VALID); end
        wait_scan_end();
        checks++; if (KEY_CODE !== 4'h7 || KEY_VALID !== 1'b1 || KEY_HELD !== 1'b1) begin
            failures++; $display("FAIL rmp_reaccept: code=%h valid=%b held=%b want 7 1 1", KEY_CODE, KEY_VALID, KEY_HELD);
        end
        pulse_ack();
        keys = 16'h0000;
        wait_scan_end();
        wait_scan_end();
    endtask

    initial begin
        Reset_n = 1'b0;
        KEY_ACK = 1'b0;
        keys    = 16'h0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
